cpu15_sequencer: RTL and testbench

Instruction-phase sequencer for the CPU15 core. Steps each instruction through fetch, decode, execute and write-back with one-cycle phase strobes, and owns the 8-bit program counter. The program counter feeds the program ROM address and is updated by increment, jump or halt. The block sits between the top-level clock/reset and the fetch, decode, execute and register-file stages, and replaces free-running per-stage clocks with one controlled sequence.

---
 rtl/cpu15_pkg.sv | 15 +
 rtl/cpu15_edge_det.sv | 13 +
 rtl/cpu15_sequencer.sv | 80 ++++++++
 tb/tb_cpu15_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu15_pkg.sv
// cpu15_pkg: shared constants for the CPU15 instruction-phase sequencer.
package cpu15_pkg;
  localparam int DEF_PC_W = 8;
  localparam int DEF_RESET_PC = 0;
  localparam int PH_FT_I = 0;
  localparam int PH_DC_I = 1;
  localparam int PH_EX_I = 2;
  localparam int PH_WB_I = 3;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FT = 3'd1;
  localparam logic [2:0] S_DC = 3'd2;
  localparam logic [2:0] S_EX = 3'd3;
  localparam logic [2:0] S_WB = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;
endpackage

// File: rtl/cpu15_edge_det.sv
// cpu15_edge_det: registered rising-edge detector for the STEP request.
module cpu15_edge_det (
  input  logic CLK,
  input  logic RESET_N,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/cpu15_sequencer.sv
// cpu15_sequencer: FT/DC/EX/WB phase sequencer owning the program counter.
// Optional single-step input enabled by CPU15_STEP_EN.
module cpu15_sequencer
  import cpu15_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int RESET_PC = DEF_RESET_PC,
  parameter int CNT_W = 16
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            RUN,
`ifdef CPU15_STEP_EN
  input  logic            STEP,
`endif
  input  logic            HALT_REQ,
  input  logic            JMP_EN,
  input  logic [PC_W-1:0] JMP_ADDR,
  output logic            PH_FT,
  output logic            PH_DC,
  output logic            PH_EX,
  output logic            PH_WB,
  output logic [PC_W-1:0] P_COUNT,
  output logic            HALTED,
  output logic [CNT_W-1:0] RETIRED
);
  logic [2:0] state, state_nxt;
  logic [3:0] ph;
  logic halt_l, jmp_l, step_go;
  logic [PC_W-1:0] jaddr_l;
`ifdef CPU15_STEP_EN
  cpu15_edge_det u_step (.CLK(CLK), .RESET_N(RESET_N), .d(STEP), .rise(step_go));
`else
  assign step_go = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = (RUN || step_go) ? S_FT : S_IDLE;
      S_FT:   state_nxt = S_DC;
      S_DC:   state_nxt = S_EX;
      S_EX:   state_nxt = S_WB;
      S_WB:   state_nxt = halt_l ? S_HALT : RUN ? S_FT : S_IDLE;
      default: state_nxt = S_HALT;
    endcase
  end
  // Strobes are decoded from the next state so they are true flop outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      ph <= '0;
      P_COUNT <= PC_W'(RESET_PC);
      HALTED <= 1'b0;
      RETIRED <= '0;
      halt_l <= 1'b0;
      jmp_l <= 1'b0;
      jaddr_l <= '0;
    end else begin
      state <= state_nxt;
      ph[PH_FT_I] <= state_nxt == S_FT;
      ph[PH_DC_I] <= state_nxt == S_DC;
      ph[PH_EX_I] <= state_nxt == S_EX;
      ph[PH_WB_I] <= state_nxt == S_WB;
      HALTED <= state_nxt == S_HALT;
      if (state == S_EX) begin
        halt_l <= HALT_REQ;
        jmp_l <= JMP_EN;
        jaddr_l <= JMP_ADDR;
      end
      if (state == S_WB) begin
        RETIRED <= RETIRED + 1'b1;
        P_COUNT <= halt_l ? P_COUNT : jmp_l ? jaddr_l : P_COUNT + 1'b1;
      end
    end
  end
  assign PH_FT = ph[PH_FT_I];
  assign PH_DC = ph[PH_DC_I];
  assign PH_EX = ph[PH_EX_I];
  assign PH_WB = ph[PH_WB_I];
endmodule

// File: tb/tb_cpu15_sequencer.sv
// tb_cpu15_sequencer: directed self-checking bench for cpu15_sequencer.
// Exercises the STEP port too when CPU15_STEP_EN is defined.
module tb_cpu15_sequencer;
  logic clk = 1'b0;
  logic rst_n, run, run2, step, halt_req, jmp_en;
  logic [7:0] jmp_addr;
  logic ph_ft, ph_dc, ph_ex, ph_wb, halted;
  logic [7:0] pc;
  logic [15:0] retired;
  logic ph2_ft, ph2_dc, ph2_ex, ph2_wb, halted2;
  logic [7:0] pc2;
  logic [15:0] retired2;
  logic [3:0] ph, ph2;
  int compared = 0;
  int mismatched = 0;
  localparam logic [3:0] FT = 4'b0001, DC = 4'b0010, EX = 4'b0100, WB = 4'b1000;

  always #5 clk = ~clk;
  assign ph = {ph_wb, ph_ex, ph_dc, ph_ft};
  assign ph2 = {ph2_wb, ph2_ex, ph2_dc, ph2_ft};

  cpu15_sequencer dut (
    .CLK(clk), .RESET_N(rst_n), .RUN(run),
`ifdef CPU15_STEP_EN
    .STEP(step),
`endif
    .HALT_REQ(halt_req), .JMP_EN(jmp_en), .JMP_ADDR(jmp_addr),
    .PH_FT(ph_ft), .PH_DC(ph_dc), .PH_EX(ph_ex), .PH_WB(ph_wb),
    .P_COUNT(pc), .HALTED(halted), .RETIRED(retired)
  );

  cpu15_sequencer #(.RESET_PC(255)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .RUN(run2),
`ifdef CPU15_STEP_EN
    .STEP(1'b0),
`endif
    .HALT_REQ(1'b0), .JMP_EN(1'b0), .JMP_ADDR(8'd0),
    .PH_FT(ph2_ft), .PH_DC(ph2_dc), .PH_EX(ph2_ex), .PH_WB(ph2_wb),
    .P_COUNT(pc2), .HALTED(halted2), .RETIRED(retired2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input logic [7:0] p, input logic [3:0] f);
    int n = 0;
    while (!(pc == p && ph == f) && n < 200) begin
      tick();
      n++;
    end
    check("wait_reached", 32'(n < 200), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; run2 = 1'b0; step = 1'b0;
    halt_req = 1'b0; jmp_en = 1'b0; jmp_addr = 8'd0;
    tick(); tick();
    check("rst_ph", 32'(ph), 32'h0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_pc2", 32'(pc2), 32'd255);
    rst_n = 1'b1;
    tick();
    check("idle_ph", 32'(ph), 32'h0);
    // Wrap: the RESET_PC=255 instance runs one instruction
    run2 = 1'b1;
    tick();
    check("wrap_ft", 32'(ph2), 32'(FT));
    run2 = 1'b0;
    tick(); tick(); tick(); tick();
    check("wrap_pc", 32'(pc2), 32'd0);
    check("wrap_idle", 32'(ph2), 32'h0);
    check("wrap_retired", 32'(retired2), 32'd1);
    check("norun_idle", 32'(ph), 32'h0);
    // Linear run
    run = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int p = 0; p < 4; p++) begin
        tick();
        check("lin_ph", 32'(ph), 32'(4'b0001 << p));
        check("lin_pc", 32'(pc), 32'(i));
      end
    tick();
    check("lin_pc5", 32'(pc), 32'd5);
    check("lin_ret5", 32'(retired), 32'd5);
    check("lin_ft", 32'(ph), 32'(FT));
    // Jump at PC 12
    wait_for(8'd12, EX);
    check("jmp_ret_before", 32'(retired), 32'd12);
    jmp_en = 1'b1; jmp_addr = 8'd7;
    tick();
    jmp_en = 1'b0; jmp_addr = 8'd0;
    check("jmp_wb", 32'(ph), 32'(WB));
    check("jmp_pc_stable", 32'(pc), 32'd12);
    tick();
    check("jmp_ft", 32'(ph), 32'(FT));
    check("jmp_pc", 32'(pc), 32'd7);
    check("jmp_ret", 32'(retired), 32'd13);
    // Jump outside EX is ignored
    jmp_en = 1'b1; jmp_addr = 8'd9;
    tick();
    jmp_en = 1'b0;
    tick(); tick(); tick();
    check("jmp_ign_pc", 32'(pc), 32'd8);
    // Halt with simultaneous jump at PC 13
    wait_for(8'd13, EX);
    halt_req = 1'b1; jmp_en = 1'b1; jmp_addr = 8'd3;
    tick();
    halt_req = 1'b0; jmp_en = 1'b0;
    check("hlt_wb", 32'(ph), 32'(WB));
    check("hlt_not_yet", 32'(halted), 32'd0);
    tick();
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_pc", 32'(pc), 32'd13);
    check("hlt_ret", 32'(retired), 32'd20);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hlt_ph0", 32'(ph), 32'h0);
      check("hlt_stay", 32'(halted), 32'd1);
    end
    // RUN drop during DC at PC 2
    rst_n = 1'b0;
    #1;
    check("hlt_rst_halted", 32'(halted), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_for(8'd2, DC);
    run = 1'b0;
    tick();
    check("drop_ex", 32'(ph), 32'(EX));
    tick();
    check("drop_wb", 32'(ph), 32'(WB));
    tick();
    check("drop_idle", 32'(ph), 32'h0);
    check("drop_pc", 32'(pc), 32'd3);
    check("drop_ret", 32'(retired), 32'd3);
    tick(); tick();
    check("drop_noft", 32'(ph), 32'h0);
    // Asynchronous reset mid-EX
    run = 1'b1;
    wait_for(8'd3, EX);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ph", 32'(ph), 32'h0);
    check("arst_pc", 32'(pc), 32'd0);
    check("arst_ret", 32'(retired), 32'd0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle", 32'(ph), 32'h0);
`ifdef CPU15_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_ft", 32'(ph), 32'(FT));
    tick();
    check("step_dc", 32'(ph), 32'(DC));
    tick();
    check("step_ex", 32'(ph), 32'(EX));
    tick();
    check("step_wb", 32'(ph), 32'(WB));
    tick();
    check("step_idle", 32'(ph), 32'h0);
    check("step_ret", 32'(retired), 32'd1);
    check("step_pc", 32'(pc), 32'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
